// File: rtl/modmul_pkg.sv
// Shared types and width helpers for the bit-serial modular multiplier.
package modmul_pkg;

   // Controller states; LOAD is kept for encoding compatibility, IDLE performs the capture itself
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RED,
      S_MUL,
      S_DONE
   } state_t;

   // Accumulators carry two guard bits so 2R + addend (< 3p) never overflows
   localparam int unsigned ACC_GUARD = 2;

   function automatic int unsigned acc_width(input int unsigned n);
      return n + ACC_GUARD;
   endfunction

endpackage

// File: rtl/modmul_step.sv
// One interleaved reduction step: T = 2R + addend, then subtract p up to twice.
module modmul_step
   import modmul_pkg::*;
#(
   parameter int unsigned n = 10,
   localparam int unsigned W = acc_width(n)
) (
   input  logic [W-1:0] i_r,
   input  logic [W-1:0] i_addend,
   input  logic [n-1:0] i_p,
   output logic [W-1:0] o_t
);

   logic [W-1:0] w_p;
   logic [W-1:0] w_t0;
   logic [W-1:0] w_t1;

   // Double-and-add followed by two conditional subtractions (T < 3p when R, addend < p)
   always_comb begin
      w_p  = W'(i_p);
      w_t0 = (i_r << 1) + i_addend;
      w_t1 = (w_t0 >= w_p) ? (w_t0 - w_p) : w_t0;
      o_t  = (w_t1 >= w_p) ? (w_t1 - w_p) : w_t1;
   end

endmodule

// File: rtl/mod_multiplier.sv
// Sequential modular multiplier M = (A*B) mod p: reduce B first, then MSB-first Blakley over A.
module mod_multiplier
   import modmul_pkg::*;
#(
   parameter int unsigned n = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic [n-1:0] p,
   output logic [n-1:0] M,
   output logic         flag
);

   localparam int unsigned W  = acc_width(n);
   localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;

   state_t r_state;
   state_t w_next;

   logic [n-1:0]  r_a;
   logic [n-1:0]  r_b;
   logic [n-1:0]  r_p;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_bred;
   logic [CW-1:0] r_cnt;
   logic [n-1:0]  r_m;
   logic          r_flag;

   logic          w_load;
   logic          w_red;
   logic          w_mul;
   logic          w_last;
   logic [W-1:0]  w_addend;
   logic [W-1:0]  w_t;

   assign w_last = (r_cnt == '0);
   assign M      = r_m;
   assign flag   = r_flag;

   modmul_step #(.n(n)) u_step (
      .i_r      (r_acc),
      .i_addend (w_addend),
      .i_p      (r_p),
      .o_t      (w_t)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state: each phase runs until the bit counter reaches zero
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = S_RED;
         S_LOAD:  w_next = S_RED;
         S_RED:   if (w_last) w_next = S_MUL;
         S_MUL:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath controls and step addend: B bit during reduction, Bred or 0 during multiply
   always_comb begin
      w_load   = 1'b0;
      w_red    = 1'b0;
      w_mul    = 1'b0;
      w_addend = '0;
      case (r_state)
         S_IDLE: w_load = 1'b1;
         S_RED: begin
            w_red    = 1'b1;
            w_addend = W'(r_b[r_cnt]);
         end
         S_MUL: begin
            w_mul    = 1'b1;
            w_addend = r_a[r_cnt] ? r_bred : '0;
         end
         default: ;
      endcase
   end

   // Operand capture, accumulator/counter update and result latch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_p    <= '0;
         r_acc  <= '0;
         r_bred <= '0;
         r_cnt  <= '0;
         r_m    <= '0;
         r_flag <= 1'b0;
      end else begin
         if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_p   <= p;
            r_acc <= '0;
            r_cnt <= CW'(n - 1);
         end
         if (w_red) begin
            if (w_last) begin
               r_bred <= w_t;
               r_acc  <= '0;
               r_cnt  <= CW'(n - 1);
            end else begin
               r_acc  <= w_t;
               r_cnt  <= r_cnt - CW'(1);
            end
         end
         if (w_mul) begin
            r_acc <= w_t;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
               // With p = 0 the accumulator is meaningless, so the result is forced to zero
               r_m    <= (r_p == '0) ? {n{1'b0}} : w_t[n-1:0];
               r_flag <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mod_multiplier.sv
// Self-checking bench for mod_multiplier (n = 10): directed table, randomized runs, corner sequences.
module tb_mod_multiplier;

   localparam int N   = 10;
   localparam int LAT = 2 * N;   // edges after E0 until flag is visible

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] A = '0;
   logic [N-1:0] B = '0;
   logic [N-1:0] p = '0;
   logic [N-1:0] M;
   logic         flag;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int a;
      int b;
      int p;
      int m;
   } vec_t;

   vec_t vecs[8];

   mod_multiplier #(.n(N)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .p     (p),
      .M     (M),
      .flag  (flag)
   );

   always #5 clk = ~clk;

   function automatic int ref_mod(input int a, input int b, input int pm);
      longint unsigned prod;
      if (pm == 0) return 0;
      prod = longint'(a) * longint'(b);
      return int'(prod % longint'(pm));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Pulse reset for one edge with the operands applied; the next posedge is E0
   task automatic start_run(input int a, input int b, input int pm);
      @(negedge clk);
      reset = 1'b1;
      A = N'(a);
      B = N'(b);
      p = N'(pm);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Count edges until flag rises; -1 if it never does within the budget
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 0; k < 4 * LAT; k++) begin
         @(posedge clk);
         #1;
         if (flag) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int ra, rb, rp;

      vecs[0] = '{a: 729,  b: 867,  p: 8,    m: 3};
      vecs[1] = '{a: 5,    b: 5,    p: 7,    m: 4};
      vecs[2] = '{a: 0,    b: 1023, p: 13,   m: 0};
      vecs[3] = '{a: 1023, b: 1023, p: 1021, m: 4};
      vecs[4] = '{a: 777,  b: 555,  p: 1,    m: 0};
      vecs[5] = '{a: 321,  b: 999,  p: 0,    m: 0};
      vecs[6] = '{a: 1023, b: 1,    p: 1023, m: 0};
      vecs[7] = '{a: 100,  b: 200,  p: 997,  m: 60};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_flag", 32'(flag), 32'd0);
      check("reset_M", 32'(M), 32'd0);

      // Directed table
      foreach (vecs[i]) begin
         start_run(vecs[i].a, vecs[i].b, vecs[i].p);
         wait_done(lat);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(LAT));
         check($sformatf("tbl%0d_M", i), 32'(M), 32'(vecs[i].m));
      end

      // Randomized operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         ra = int'($urandom_range(0, 1023));
         rb = int'($urandom_range(0, 1023));
         rp = (i % 6 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
         start_run(ra, rb, rp);
         wait_done(lat);
         check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(LAT));
         check($sformatf("rnd%0d_M(%0d*%0d%%%0d)", i, ra, rb, rp), 32'(M), 32'(ref_mod(ra, rb, rp)));
      end

      // Abort: reset reasserted so that it is sampled at E5
      start_run(1000, 999, 997);
      repeat (5) @(posedge clk);   // E0..E4
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);              // E5
      #1;
      check("abort_flag", 32'(flag), 32'd0);
      check("abort_M", 32'(M), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_hold_flag", 32'(flag), 32'd0);
      end
      @(negedge clk);
      A = 10'd3;
      B = 10'd4;
      p = 10'd5;
      reset = 1'b0;
      wait_done(lat);
      check("abort_rerun_latency", 32'(lat), 32'(LAT));
      check("abort_rerun_M", 32'(M), 32'd2);

      // Operands changed right after E0 must not affect the result
      start_run(6, 5, 7);
      @(posedge clk);              // E0
      #1;
      A = 10'd3;
      B = 10'd3;
      p = 10'd11;
      wait_done(lat);
      check("capture_latency", 32'(lat), 32'(LAT - 1));
      check("capture_M", 32'(M), 32'd2);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("done_hold_M", 32'(M), 32'd2);
         check("done_hold_flag", 32'(flag), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mod_multiplier.md
# mod_multiplier

Sequential modular multiplier computing M = (A·B) mod p for n-bit unsigned operands, one result per reset-initiated run. Bit-serial design: it first reduces B modulo p, then performs interleaved (Blakley) shift-add-reduce over the bits of A, MSB first. It is the multiply primitive beneath the ECC point arithmetic and scalar-multiplication datapath. A and B may be any n-bit values, including values ≥ p.

## Interface
- n, default 10: operand, modulus and result width in bits.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high. Deassertion starts a new operation.
- A  input  n  multiplicand, unsigned.
- B  input  n  multiplier, unsigned.
- p  input  n  modulus, unsigned.
- M  output  n  registered result (A·B) mod p.
- flag  output  1  registered done; high while M is valid.

## Operation
- States: IDLE, LOAD, RED, MUL, DONE.
- Reset edge (reset=1): state←IDLE, M←0, flag←0, internal registers cleared.
- IDLE: first edge with reset=0 captures A, B, p into internal registers (LOAD action), counter←n−1, R←0; → RED.
- RED (n iterations, i = n−1 … 0):
  - R ← 2R + B[i].
  - If R ≥ p, then R ← R − p.
  - At i=0, Bred ← reduced value; R←0; → MUL.
- MUL (n iterations, i = n−1 … 0):
  - T ← 2R + (A[i] ? Bred : 0).
  - Subtract p while T ≥ p, at most twice because T < 3p.
  - R ← T.
  - At i=0, M←R, flag←1; → DONE.
- DONE: M and flag hold until reset. A, B and p are ignored after capture; input changes mid-run do not affect the result.
- Width rules: internal accumulators are n+2 bits; comparisons are unsigned.
- p=0: M←0 and flag still asserts with normal latency.
- p=1: result 0.

## Timing
- E0 = first rising edge with reset=0; operands are sampled at E0.
- RED occupies E1..En. MUL occupies En+1..E2n.
- M and flag update at E2n, so flag is visible after E2n. Latency is 2n+1 edges including E0; 21 edges for n=10.
- No start or handshake signal; each run starts on reset deassertion.
- Reset asserted mid-operation: aborts at that edge; M=0 and flag=0 on the next edge; a fresh run starts when reset deasserts.
- flag never pulses; it is level-high until reset.

## Structure
- Shared package modmul_pkg:
  - state enum (IDLE, LOAD, RED, MUL, DONE);
  - width helper constant for n+2 accumulators.
- One sub-module, modmul_step, is natural: combinational doubling plus conditional add plus up-to-two conditional subtract. It is used by both phases, with the addend set to B[i] in RED and to Bred/0 in MUL.
- The top level holds the FSM, counter and registers.

## Test plan
- n=10, A=729, B=867, p=8, reset released → flag high after 21 edges, M=3.
- A=5, B=5, p=7 → M=4. A=0, B=1023, p=13 → M=0.
- A=1023, B=1023, p=1021 → M=4; checks operands ≥ p and the double-subtract path.
- p=1 → M=0. p=0 → M=0. In both cases flag asserts at the normal latency.
- Reset reasserted at E5 of a run, released later with A=3, B=4, p=5 → flag low during reset, then M=2 after 21 edges.
- A, B and p changed after E0 → result reflects the values captured at E0; M and flag stable in DONE for ≥10 further cycles.
